// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter + 11-bit deframer + FWFT byte FIFO.
// Latency: pad edge of stop bit to VALID = 2 (sync) + FILTER_LEN (filter) + 1 (push) cycles.
// Backpressure: READY low holds bytes in the FIFO; when full, good frames are dropped (OVF),
//   or with PS2_INHIBIT_EN defined the PS/2 clock is held low until the consumer pops.
//
// Ports:
//   CLK, nRST         system clock, asynchronous active-low reset
//   PS2CLK, PS2DAT    raw asynchronous pads, idle high
//   DATA, VALID, READY  FIFO head byte with valid/ready handshake (pop on VALID&READY)
//   PERR, FERR, OVF   one-cycle error pulses (parity, stop/timeout, overflow)
//   PS2CLK_OE         1 = pull the PS/2 clock pad low (only active with PS2_INHIBIT_EN)
//
// Optional feature macro: PS2_INHIBIT_EN

// Small first-word-fall-through FIFO; head is valid whenever empty is low.
// Caller must not push when full unless popping in the same cycle, nor pop when empty.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);
endmodule

module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_AW     = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       PS2CLK,
  input  logic       PS2DAT,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF,
  output logic       PS2CLK_OE
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    FLT_LAST = 8'(FILTER_LEN - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic       clk_s1, clk_s2, dat_s1, dat_s2;
  logic       clk_f, clk_f_d;
  logic [7:0] flt_cnt;
  logic       fall;
  logic       inh;

  state_t        state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [8:0]    shreg_q, shreg_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          perr_d, ferr_d, ovf_d;
  logic          push, pop, full, empty;
  logic [7:0]    head;

  // Two-flop synchronisers; idle-high pads so reset to 1.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2DAT;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered clock only follows after FILTER_LEN consecutive differing samples;
  // any return to the old level restarts the count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 != clk_f) begin
        if (flt_cnt == FLT_LAST) begin
          clk_f   <= clk_s2;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 8'd1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  // While inhibiting, a fall is our own pull-down, not a device bit.
  assign fall = clk_f_d & ~clk_f & ~inh;
  assign pop  = VALID & READY;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      tcnt_q   <= '0;
      PERR     <= 1'b0;
      FERR     <= 1'b0;
      OVF      <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      tcnt_q   <= tcnt_d;
      PERR     <= perr_d;
      FERR     <= ferr_d;
      OVF      <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tcnt_d   = tcnt_q;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    ovf_d    = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (fall && !dat_s2) begin
          state_d  = RECV;
          bitcnt_d = 4'd1;
        end
      end
      RECV: begin
        if (fall) begin
          tcnt_d = '0;
          if (bitcnt_q == 4'd10) begin
            // Stop-bit fall: shreg holds {parity, data[7:0]}.
            state_d  = IDLE;
            bitcnt_d = '0;
            if (!dat_s2)              ferr_d = 1'b1;
            else if (!(^shreg_q))     perr_d = 1'b1;
            else if (full && !pop)    ovf_d  = 1'b1;
            else                      push   = 1'b1;
          end else begin
            shreg_d  = {dat_s2, shreg_q[8:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (tcnt_q == TMO_LAST) begin
          ferr_d   = 1'b1;
          state_d  = IDLE;
          bitcnt_d = '0;
          tcnt_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PS2_INHIBIT_EN
  // Hold the device off once the FIFO is full and no frame is in flight;
  // release as soon as the consumer frees a slot.
  logic inh_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          inh_q <= 1'b0;
    else if (pop)                       inh_q <= 1'b0;
    else if (full && state_q == IDLE)   inh_q <= 1'b1;
  end
  assign inh = inh_q;
`else
  assign inh = 1'b0;
`endif

  assign PS2CLK_OE = inh;

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .push     (push),
    .push_dat (shreg_q[7:0]),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full)
  );

  assign VALID = ~empty;
  assign DATA  = VALID ? head : 8'h00;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames on the pads, scoreboards popped bytes
// against bytes queued at stimulus time, and counts error pulses per scenario.
module tb_ps2_rx_fifo;
  localparam int FL  = 8;
  localparam int TMO = 200;
  localparam int H   = 20;   // half bit period in CLK cycles

  logic       clk;
  logic       nrst;
  logic       ps2clk;
  logic       ps2dat;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       perr;
  logic       ferr;
  logic       ovf;
  logic       oe;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf  = 0;
  int n_vld  = 0;
  int cyc_n  = 0;
  int ferr_at = 0;
  int fall_at = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO), .FIFO_AW(2)) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .PS2CLK    (ps2clk),
    .PS2DAT    (ps2dat),
    .DATA      (data),
    .VALID     (valid),
    .READY     (ready),
    .PERR      (perr),
    .FERR      (ferr),
    .OVF       (ovf),
    .PS2CLK_OE (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: observe on the falling edge, then return 2 ns after the rising edge.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (nrst && valid && ready) obs_q.push_back(data);
    if (perr)  n_perr++;
    if (ferr) begin n_ferr++; ferr_at = cyc_n; end
    if (ovf)   n_ovf++;
    if (valid) n_vld++;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par,
                            input int nbits, input int glitch_after);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2dat = bits[i];
      repeat (H) cyc();
      ps2clk  = 1'b0;
      fall_at = cyc_n;
      repeat (H) cyc();
      ps2clk = 1'b1;
      if (i == glitch_after) begin
        repeat (12) cyc();
        ps2clk = 1'b0;
        repeat (3) cyc();
        ps2clk = 1'b1;
      end
    end
    ps2dat = 1'b1;
    repeat (30) cyc();
  endtask

  task automatic test_reset();
    nrst = 1'b0; ps2clk = 1'b1; ps2dat = 1'b1; ready = 1'b0;
    #3;
    n_vec++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_vec++; if (perr !== 1'b0)  begin n_bad++; $display("FAIL reset_perr: got %b want 0", perr); end
    n_vec++; if (ferr !== 1'b0)  begin n_bad++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    n_vec++; if (ovf !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_vec++; if (oe !== 1'b0)    begin n_bad++; $display("FAIL reset_oe: got %b want 0", oe); end
    repeat (3) @(posedge clk);
    #2;
    nrst = 1'b1;
    repeat (5) cyc();
  endtask

  task automatic test_good_frame();
    int v0, p0, f0, o0;
    logic [7:0] e, o;
    ready = 1'b1;
    v0 = n_vld; p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 11, -1);
    n_vec++; if (n_vld - v0 != 1) begin n_bad++; $display("FAIL good_valid_cycles: got %0d want 1", n_vld - v0); end
    n_vec++; if (n_perr - p0 + n_ferr - f0 + n_ovf - o0 != 0) begin
      n_bad++; $display("FAIL good_err_pulses: got %0d want 0", n_perr - p0 + n_ferr - f0 + n_ovf - o0);
    end
    n_vec++; if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL good_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL good_data: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_parity_error();
    int v0, p0, f0;
    ready = 1'b1;
    v0 = n_vld; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 11, -1);
    n_vec++; if (n_perr - p0 != 1) begin n_bad++; $display("FAIL par_perr_cycles: got %0d want 1", n_perr - p0); end
    n_vec++; if (n_vld - v0 != 0)  begin n_bad++; $display("FAIL par_valid_cycles: got %0d want 0", n_vld - v0); end
    n_vec++; if (n_ferr - f0 != 0) begin n_bad++; $display("FAIL par_ferr: got %0d want 0", n_ferr - f0); end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL par_popped: got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_overflow();
    int o0;
    logic [7:0] e, o;
    ready = 1'b0;
    o0 = n_ovf;
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b0, 11, -1);
    end
    n_vec++; if (n_ovf - o0 != 0) begin n_bad++; $display("FAIL ovf_early: got %0d want 0", n_ovf - o0); end
    n_vec++; if (valid !== 1'b1)  begin n_bad++; $display("FAIL ovf_valid_full: got %b want 1", valid); end
    send_frame(8'h05, 1'b0, 11, -1);
    n_vec++; if (n_ovf - o0 != 1) begin n_bad++; $display("FAIL ovf_pulse: got %0d want 1", n_ovf - o0); end
    ready = 1'b1;
    repeat (10) cyc();
    n_vec++; if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL ovf_order: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", valid); end
  endtask

  task automatic test_timeout();
    int f0;
    logic [7:0] e, o;
    ready = 1'b1;
    f0 = n_ferr;
    send_frame(8'h00, 1'b0, 5, -1);   // start bit + 4 data bits, then idle
    repeat (TMO + 50) cyc();
    n_vec++; if (n_ferr - f0 != 1) begin n_bad++; $display("FAIL tmo_ferr_cycles: got %0d want 1", n_ferr - f0); end
    // pad fall -> filtered fall after 2+FL edges, tcnt hits TMO-1 after TMO more,
    // registered pulse one edge later, seen at the following falling edge.
    n_vec++; if (ferr_at - fall_at != FL + TMO + 4) begin
      n_bad++; $display("FAIL tmo_delay: got %0d want %0d", ferr_at - fall_at, FL + TMO + 4);
    end
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 11, -1);
    n_vec++; if (n_ferr - f0 != 1) begin n_bad++; $display("FAIL tmo_next_ferr: got %0d want 1", n_ferr - f0); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL tmo_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL tmo_data: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    int p0, f0;
    logic [7:0] e, o;
    ready = 1'b1;
    p0 = n_perr; f0 = n_ferr;
    // Idle glitch with data low: would look like a start bit if it got through.
    ps2dat = 1'b0;
    repeat (5) cyc();
    ps2clk = 1'b0;
    repeat (3) cyc();
    ps2clk = 1'b1;
    repeat (20) cyc();
    ps2dat = 1'b1;
    repeat (20) cyc();
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, 1'b0, 11, 4);   // glitch during the high phase after bit 4
    n_vec++; if (n_perr - p0 != 0) begin n_bad++; $display("FAIL glitch_perr: got %0d want 0", n_perr - p0); end
    n_vec++; if (n_ferr - f0 != 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL glitch_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL glitch_data: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] e, o;
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 11, -1);
    send_frame(8'h22, 1'b0, 11, -1);
    n_vec++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rst_prefill_valid: got %b want 1", valid); end
    send_frame(8'h33, 1'b0, 6, -1);   // partial frame in flight
    nrst = 1'b0;
    #1;
    n_vec++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid_async: got %b want 0", valid); end
    repeat (3) @(posedge clk);
    #2;
    nrst  = 1'b1;
    ready = 1'b1;
    repeat (5) cyc();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 11, -1);
    n_vec++; if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rst_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL rst_data: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
